// File: rtl/nand_op_sequencer.sv
// Bitwise logic-op sequencer: every operation is built from one shared WIDTH-bit NAND, one evaluation per clock.
// Optional NAND_USE_COUNT_EN adds a saturating 16-bit count of NAND evaluations.
module nand_op_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
`ifdef NAND_USE_COUNT_EN
    output logic [15:0]      nand_count,
`endif
    output logic [WIDTH-1:0] y
);
    typedef enum logic {S_IDLE, S_EXEC} state_t;
    typedef enum logic [2:0] {SRC_A, SRC_B, SRC_T, SRC_U, SRC_V} src_t;
    typedef enum logic [1:0] {DST_T, DST_U, DST_V, DST_Y} dst_t;

    state_t           r_state, w_state_next;
    logic [2:0]       r_op, r_step;
    logic [WIDTH-1:0] r_a, r_b, r_t, r_u, r_v, r_y;
    logic             r_busy, r_done;
    src_t             w_xs, w_zs;
    dst_t             w_dst;
    logic             w_last;
    logic [WIDTH-1:0] w_x, w_z, w_n;

    // Per-op step schedule: operand sources, destination and final-step flag.
    always_comb begin
        w_xs   = SRC_A;
        w_zs   = SRC_B;
        w_dst  = DST_Y;
        w_last = 1'b0;
        case (r_op)
            3'd0: w_last = 1'b1;
            3'd1: case (r_step)
                3'd0:    w_dst = DST_T;
                default: begin w_xs = SRC_T; w_zs = SRC_T; w_last = 1'b1; end
            endcase
            3'd2: case (r_step)
                3'd0:    begin w_zs = SRC_A; w_dst = DST_T; end
                3'd1:    begin w_xs = SRC_B; w_dst = DST_U; end
                default: begin w_xs = SRC_T; w_zs = SRC_U; w_last = 1'b1; end
            endcase
            3'd3: case (r_step)
                3'd0:    begin w_zs = SRC_A; w_dst = DST_T; end
                3'd1:    begin w_xs = SRC_B; w_dst = DST_U; end
                3'd2:    begin w_xs = SRC_T; w_zs = SRC_U; w_dst = DST_V; end
                default: begin w_xs = SRC_V; w_zs = SRC_V; w_last = 1'b1; end
            endcase
            3'd4, 3'd5: case (r_step)
                3'd0:    w_dst = DST_T;
                3'd1:    begin w_zs = SRC_T; w_dst = DST_U; end
                3'd2:    begin w_xs = SRC_B; w_zs = SRC_T; w_dst = DST_V; end
                3'd3:    begin
                    w_xs = SRC_U; w_zs = SRC_V;
                    if (r_op == 3'd5) w_dst = DST_T;
                    else              w_last = 1'b1;
                end
                default: begin w_xs = SRC_T; w_zs = SRC_T; w_last = 1'b1; end
            endcase
            3'd6: begin w_zs = SRC_A; w_last = 1'b1; end
            default: case (r_step)
                3'd0:    begin w_zs = SRC_A; w_dst = DST_T; end
                default: begin w_xs = SRC_T; w_zs = SRC_T; w_last = 1'b1; end
            endcase
        endcase
    end

    always_comb begin
        case (w_xs)
            SRC_A:   w_x = r_a;
            SRC_B:   w_x = r_b;
            SRC_T:   w_x = r_t;
            SRC_U:   w_x = r_u;
            default: w_x = r_v;
        endcase
        case (w_zs)
            SRC_A:   w_z = r_a;
            SRC_B:   w_z = r_b;
            SRC_T:   w_z = r_t;
            SRC_U:   w_z = r_u;
            default: w_z = r_v;
        endcase
        w_n = ~(w_x & w_z);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_EXEC;
            default: if (w_last) w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_t    <= '0;
            r_u    <= '0;
            r_v    <= '0;
            r_y    <= '0;
            r_step <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_op   <= op;
                    r_a    <= a;
                    r_b    <= b;
                    r_step <= '0;
                    r_busy <= 1'b1;
                end
            end else begin
                case (w_dst)
                    DST_T:   r_t <= w_n;
                    DST_U:   r_u <= w_n;
                    DST_V:   r_v <= w_n;
                    default: r_y <= w_n;
                endcase
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_step <= r_step + 3'd1;
                end
            end
        end
    end

`ifdef NAND_USE_COUNT_EN
    logic [15:0] r_count;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         r_count <= '0;
        else if (r_state == S_EXEC && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
    end
    assign nand_count = r_count;
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign y    = r_y;
endmodule

// File: tb/tb_nand_op_sequencer.sv
// Self-checking bench for nand_op_sequencer: directed scenarios plus random ops against a bitwise reference.
module tb_nand_op_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = '0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done;
    logic [7:0] y;
`ifdef NAND_USE_COUNT_EN
    logic [15:0] nand_count;
`endif

    int errors = 0;
    int checks = 0;
    int steps_tbl [8] = '{1, 2, 3, 4, 4, 5, 1, 2};

    nand_op_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done),
`ifdef NAND_USE_COUNT_EN
        .nand_count(nand_count),
`endif
        .y(y)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        case (o)
            3'd0: return ~(x & z);
            3'd1: return x & z;
            3'd2: return x | z;
            3'd3: return ~(x | z);
            3'd4: return x ^ z;
            3'd5: return ~(x ^ z);
            3'd6: return ~x;
            default: return x;
        endcase
    endfunction

    // Drives one request, scrambles inputs after acceptance, returns edges counted until done (incl. accept edge).
    task automatic run_op(input logic [2:0] o, input logic [7:0] ia, input logic [7:0] ib, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a = ia; b = ib;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y got=%h exp=00", y); end
`ifdef NAND_USE_COUNT_EN
        checks++; if (nand_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", nand_count); end
`endif
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_all_ops();
        logic [7:0] exp_tbl [8] = '{8'h3F, 8'hC0, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
        int lat;
        for (int o = 0; o < 8; o++) begin
            run_op(3'(o), 8'hF0, 8'hCC, lat);
            checks++; if (y !== exp_tbl[o]) begin errors++; $display("FAIL op%0d_y got=%h exp=%h", o, y, exp_tbl[o]); end
            checks++; if (lat != steps_tbl[o] + 1) begin errors++; $display("FAIL op%0d_latency got=%0d exp=%0d", o, lat, steps_tbl[o] + 1); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL op%0d_busy_at_done got=%b exp=0", o, busy); end
            @(posedge clk); #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL op%0d_done_width got=%b exp=0", o, done); end
        end
        for (int i = 0; i < 30; i++) begin
            logic [2:0] ro;
            logic [7:0] ra, rb;
            ro = 3'($urandom); ra = 8'($urandom); rb = 8'($urandom);
            run_op(ro, ra, rb, lat);
            checks++; if (y !== ref_op(ro, ra, rb)) begin errors++; $display("FAIL rand_y op=%0d a=%h b=%h got=%h exp=%h", ro, ra, rb, y, ref_op(ro, ra, rb)); end
            checks++; if (lat != steps_tbl[ro] + 1) begin errors++; $display("FAIL rand_latency op=%0d got=%0d exp=%0d", ro, lat, steps_tbl[ro] + 1); end
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, pulses;
        @(negedge clk); start = 1'b1; op = 3'd4; a = 8'hF0; b = 8'hCC;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL midrst_y got=%h exp=00", y); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", pulses); end
        run_op(3'd0, 8'hFF, 8'h0F, lat);
        checks++; if (y !== 8'hF0) begin errors++; $display("FAIL midrst_after_y got=%h exp=f0", y); end
        checks++; if (lat != 2) begin errors++; $display("FAIL midrst_after_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_start_while_busy();
        int pulses, first;
        @(negedge clk); start = 1'b1; op = 3'd5; a = 8'hAA; b = 8'h55;
        @(posedge clk); #1; start = 1'b0;
        pulses = 0; first = 0;
        for (int k = 2; k <= 14; k++) begin
            if (k == 3) begin start = 1'b1; op = 3'd0; a = 8'h00; b = 8'h00; end
            if (k == 4) start = 1'b0;
            @(posedge clk); #1;
            if (done === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL busy_start_pulses got=%0d exp=1", pulses); end
        checks++; if (first != 6) begin errors++; $display("FAIL busy_start_latency got=%0d exp=6", first); end
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL busy_start_y got=%h exp=00", y); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(3'd4, 8'hF0, 8'hCC, lat);
        start = 1'b1; op = 3'd1; a = 8'h0F; b = 8'hFF;
        @(posedge clk); #1; start = 1'b0; a = 8'h00; b = 8'h00;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
        checks++; if (y !== 8'h3C) begin errors++; $display("FAIL b2b_hold_y got=%h exp=3c", y); end
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat != 2) begin errors++; $display("FAIL b2b_latency got=%0d exp=2", lat); end
        checks++; if (y !== 8'h0F) begin errors++; $display("FAIL b2b_y got=%h exp=0f", y); end
    endtask

    task automatic test_result_hold();
        int lat;
        run_op(3'd2, 8'h01, 8'h02, lat);
        checks++; if (y !== 8'h03) begin errors++; $display("FAIL hold_or_y got=%h exp=03", y); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            @(posedge clk); #1;
            checks++; if (y !== 8'h03) begin errors++; $display("FAIL hold_y cyc=%0d got=%h exp=03", k, y); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_done cyc=%0d got=%b exp=0", k, done); end
        end
    endtask

`ifdef NAND_USE_COUNT_EN
    task automatic test_count();
        int lat;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++; if (nand_count !== 16'd0) begin errors++; $display("FAIL count_reset got=%0d exp=0", nand_count); end
        run_op(3'd0, 8'($urandom), 8'($urandom), lat);
        run_op(3'd5, 8'($urandom), 8'($urandom), lat);
        run_op(3'd2, 8'($urandom), 8'($urandom), lat);
        checks++; if (nand_count !== 16'd9) begin errors++; $display("FAIL count_total got=%0d exp=9", nand_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_all_ops();
        test_reset_mid_op();
        test_start_while_busy();
        test_back_to_back();
        test_result_hold();
`ifdef NAND_USE_COUNT_EN
        test_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
